// File: rtl/rcn_pkg.sv
// Shared rcn packet definitions and arbiter state-update encoding.
package rcn_pkg;

  localparam int RCN_W       = 69;
  localparam int RCN_VLD_BIT = 68;
  localparam int RCN_DATA_W  = 68;
  localparam int ID_W        = 3;
  localparam int CNT_W       = 4;

  typedef logic [RCN_W-1:0] rcn_t;
  typedef logic [ID_W-1:0]  req_id_t;
  typedef logic [CNT_W-1:0] burst_cnt_t;

  // How the arbiter's owner/burst state moves on the next clk_in edge.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_IDLE,
    UPD_CONT,
    UPD_NEW
  } upd_e;

  function automatic logic rcn_valid(input rcn_t pkt);
    return pkt[RCN_VLD_BIT];
  endfunction

endpackage

// File: rtl/rcn_fifo_arb_if.sv
// Requester-side and FIFO-write-side signals of the rcn FIFO arbiter.
interface rcn_fifo_arb_if
  import rcn_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ*RCN_W-1:0] req_rcn;
  logic [NUM_REQ-1:0]       req_busy;
  rcn_t                     fifo_rcn;
  logic                     fifo_push;
  logic                     fifo_full;
  req_id_t                  grant_id;

  // The arbiter itself.
  modport slave (
    input  req_rcn, fifo_full,
    output req_busy, fifo_rcn, fifo_push, grant_id
  );

  // Requesters plus the FIFO write port.
  modport master (
    output req_rcn, fifo_full,
    input  req_busy, fifo_rcn, fifo_push, grant_id
  );

endinterface

// File: rtl/rcn_rr_pick.sv
// Combinational cyclic priority pick: first valid index at or after start.
module rcn_rr_pick
  import rcn_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            start,
  output logic               any_valid,
  output req_id_t            pick
);

  logic    hi_found;
  logic    lo_found;
  req_id_t hi_pick;
  req_id_t lo_pick;

  // Search [start, NUM_REQ) first; if empty, wrap to the lowest valid index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_pick  = ID_W'(i);
      end
      if (valid[i] && !hi_found && (ID_W'(i) >= start)) begin
        hi_found = 1'b1;
        hi_pick  = ID_W'(i);
      end
    end
  end

  assign any_valid = |valid;
  assign pick      = hi_found ? hi_pick : lo_pick;

endmodule

// File: rtl/rcn_fifo_arb.sv
// Round-robin arbiter with burst limit sharing one rcn FIFO push port.
module rcn_fifo_arb
  import rcn_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BURST   = 4
) (
  input logic          rst_in,
  input logic          clk_in,
  rcn_fifo_arb_if.slave bus
);

  localparam req_id_t    LAST_ID = ID_W'(NUM_REQ - 1);
  localparam burst_cnt_t BURST_C = CNT_W'(BURST);

  req_id_t            owner;
  req_id_t            owner_nxt;
  burst_cnt_t         burst_cnt;
  burst_cnt_t         burst_cnt_nxt;
  upd_e               upd;

  logic [NUM_REQ-1:0] valid;
  logic               owner_valid;
  logic               keep_owner;
  logic               any_valid;
  logic               push;
  req_id_t            start;
  req_id_t            pick;
  req_id_t            winner;
  rcn_t               fifo_rcn_c;
  logic [NUM_REQ-1:0] busy;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      valid[i] = rcn_valid(bus.req_rcn[i*RCN_W +: RCN_W]);
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) owner_valid = valid[i];
    end
  end

  assign start = (owner == LAST_ID) ? '0 : owner + ID_W'(1);

  rcn_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid     (valid),
    .start     (start),
    .any_valid (any_valid),
    .pick      (pick)
  );

  // A zero count means no burst is in progress (after reset or an idle
  // cycle), so the search starts past the owner instead of continuing it.
  assign keep_owner = owner_valid && (burst_cnt != '0) && (burst_cnt < BURST_C);
  assign winner     = keep_owner ? owner : pick;
  assign push       = any_valid && !bus.fifo_full;

  always_comb begin
    fifo_rcn_c = '0;
    busy       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push && (winner == ID_W'(i))) fifo_rcn_c = bus.req_rcn[i*RCN_W +: RCN_W];
      busy[i] = valid[i] && !(push && (winner == ID_W'(i)));
    end
  end

  assign bus.fifo_rcn  = fifo_rcn_c;
  assign bus.fifo_push = push;
  assign bus.req_busy  = busy;
  assign bus.grant_id  = push ? winner : '0;

  // A burst-exhausted lone requester re-enters through UPD_NEW and restarts at 1.
  always_comb begin
    upd           = UPD_HOLD;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    if (push)              upd = keep_owner ? UPD_CONT : UPD_NEW;
    else if (!bus.fifo_full) upd = UPD_IDLE;
    unique case (upd)
      UPD_CONT: burst_cnt_nxt = burst_cnt + CNT_W'(1);
      UPD_NEW: begin
        owner_nxt     = winner;
        burst_cnt_nxt = CNT_W'(1);
      end
      UPD_IDLE: burst_cnt_nxt = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      owner     <= LAST_ID;
      burst_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rcn_fifo_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a burst/rotation reference model.
module tb_rcn_fifo_arb;
  import rcn_pkg::*;

  localparam int N = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [N*RCN_W-1:0] req;
  logic full;

  always #5 clk_in = ~clk_in;

  rcn_fifo_arb_if #(.NUM_REQ(N)) bus4 ();
  rcn_fifo_arb_if #(.NUM_REQ(N)) bus1 ();

  assign bus4.req_rcn   = req;
  assign bus4.fifo_full = full;
  assign bus1.req_rcn   = req;
  assign bus1.fifo_full = full;

  rcn_fifo_arb #(.NUM_REQ(N), .BURST(4)) u_b4 (.rst_in(rst_in), .clk_in(clk_in), .bus(bus4));
  rcn_fifo_arb #(.NUM_REQ(N), .BURST(1)) u_b1 (.rst_in(rst_in), .clk_in(clk_in), .bus(bus1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per instance, who holds the burst and how long it has run.
  int m_owner[2];
  int m_run[2];
  int burst_of[2] = '{4, 1};

  int       obs_grant[2];
  bit       obs_push[2];
  logic [N-1:0] obs_busy[2];
  rcn_t     obs_rcn[2];
  logic [N-1:0] exp_busy0;
  int       exp_push_cnt = 0;
  int       obs_push_cnt = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = N - 1;
      m_run[k]   = 0;
    end
  endtask

  task automatic model_pick(input int inst, input logic [N-1:0] v, output int win, output bit any);
    any = (v != '0);
    win = 0;
    if (!any) return;
    if (m_run[inst] > 0 && m_run[inst] < burst_of[inst] && v[m_owner[inst]]) begin
      win = m_owner[inst];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_owner[inst] + k) % N;
        if (v[i]) begin
          win = i;
          break;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    logic [N-1:0] v;
    int       win[2];
    bit       any;
    bit       push[2];
    rcn_t     exp_rcn;
    logic [N-1:0] eb;
    bit       o_push;
    int       o_gid;
    rcn_t     o_rcn;
    logic [N-1:0] o_busy;
    @(negedge clk_in);
    for (int i = 0; i < N; i++) v[i] = req[i*RCN_W + RCN_VLD_BIT];
    for (int inst = 0; inst < 2; inst++) begin
      model_pick(inst, v, win[inst], any);
      push[inst] = any && !full;
      exp_rcn = push[inst] ? req[win[inst]*RCN_W +: RCN_W] : '0;
      eb = v;
      if (push[inst]) eb[win[inst]] = 1'b0;
      if (inst == 0) begin
        o_push = bus4.fifo_push; o_gid = int'(bus4.grant_id);
        o_rcn  = bus4.fifo_rcn;  o_busy = bus4.req_busy;
      end else begin
        o_push = bus1.fifo_push; o_gid = int'(bus1.grant_id);
        o_rcn  = bus1.fifo_rcn;  o_busy = bus1.req_busy;
      end
      check($sformatf("%s/b%0d/push", tag, burst_of[inst]), o_push, push[inst]);
      check($sformatf("%s/b%0d/grant", tag, burst_of[inst]), o_gid, push[inst] ? win[inst] : 0);
      check($sformatf("%s/b%0d/rcn", tag, burst_of[inst]), o_rcn, exp_rcn);
      check($sformatf("%s/b%0d/busy", tag, burst_of[inst]), o_busy, eb);
      obs_grant[inst] = o_gid;
      obs_push[inst]  = o_push;
      obs_busy[inst]  = o_busy;
      obs_rcn[inst]   = o_rcn;
      if (inst == 0) begin
        exp_busy0 = eb;
        if (push[0]) exp_push_cnt++;
        if (o_push)  obs_push_cnt++;
      end
    end
    @(posedge clk_in);
    if (!rst_in) begin
      for (int inst = 0; inst < 2; inst++) begin
        if (push[inst]) begin
          if (win[inst] == m_owner[inst] && m_run[inst] > 0 && m_run[inst] < burst_of[inst])
            m_run[inst]++;
          else begin
            m_owner[inst] = win[inst];
            m_run[inst]   = 1;
          end
        end else if (!full) begin
          m_run[inst] = 0;
        end
      end
    end
    #1;
  endtask

  function automatic rcn_t rand_pkt(input bit vld);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return {vld, r[RCN_DATA_W-1:0]};
  endfunction

  task automatic set_valid(input int i);
    req[i*RCN_W +: RCN_W] = rand_pkt(1'b1);
  endtask

  task automatic set_idle(input int i);
    req[i*RCN_W +: RCN_W] = rand_pkt(1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) set_idle(i);
    full   = 1'b0;
    rst_in = 1'b1;
    model_reset();
    step("rst");
    rst_in = 1'b0;
  endtask

  initial begin
    full = 1'b0;
    req  = '0;
    model_reset();
    @(posedge clk_in);
    #1;

    // Lone requester 2 is granted every cycle, never throttled.
    do_reset();
    check("t1/reset_push", obs_push[0], 1'b0);
    req[2*RCN_W +: RCN_W] = {1'b1, 68'h2_3456_789A_BCDE_F012};
    for (int k = 0; k < 10; k++) begin
      step("t1");
      check("t1/gid", obs_grant[0], 2);
      check("t1/busy", obs_busy[0], 4'b0000);
    end

    // All valid: bursts of four in index order.
    do_reset();
    for (int i = 0; i < N; i++) set_valid(i);
    for (int k = 0; k < 17; k++) begin
      step("t2");
      check("t2/seq", obs_grant[0], (k / 4) % 4);
      check("t2/b1seq", obs_grant[1], k % 4);
    end

    // FIFO full mid-burst freezes arbitration state.
    do_reset();
    set_valid(0);
    set_valid(3);
    for (int k = 0; k < 2; k++) begin
      step("t3a");
      check("t3a/gid", obs_grant[0], 0);
    end
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("t3full");
      check("t3full/push", obs_push[0], 1'b0);
      check("t3full/busy", obs_busy[0], 4'b1001);
    end
    full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step("t3b");
      check("t3b/gid", obs_grant[0], (k < 2) ? 0 : 3);
    end

    // BURST=1 alternates strictly.
    do_reset();
    set_valid(1);
    set_valid(2);
    for (int k = 0; k < 4; k++) begin
      step("t4");
      check("t4/alt", obs_grant[1], (k % 2 == 0) ? 1 : 2);
    end

    // Idle cycle mid-burst.
    do_reset();
    set_valid(1);
    step("t5a");
    step("t5a");
    set_idle(1);
    step("t5idle");
    check("t5idle/push", obs_push[0], 1'b0);
    check("t5idle/rcn", obs_rcn[0], '0);
    set_valid(1);
    for (int k = 0; k < 4; k++) begin
      step("t5b");
      check("t5b/gid", obs_grant[0], 1);
    end

    // Reset while requester 2 owns the burst restarts at requester 0.
    do_reset();
    for (int i = 0; i < N; i++) set_valid(i);
    for (int k = 0; k < 9; k++) step("t6a");
    check("t6a/owner2", obs_grant[0], 2);
    rst_in = 1'b1;
    model_reset();
    step("t6rst");
    rst_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("t6b");
      check("t6b/seq", obs_grant[0], (k < 4) ? 0 : 1);
    end

    // Random traffic; requesters hold packets while busy.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = req[i*RCN_W + RCN_VLD_BIT];
      step("rnd");
      for (int i = 0; i < N; i++) begin
        if (v[i] && !exp_busy0[i]) begin
          if ($urandom_range(0, 9) < 7) set_valid(i);
          else set_idle(i);
        end else if (!v[i] && $urandom_range(0, 9) < 4) begin
          set_valid(i);
        end
      end
      full = ($urandom_range(0, 3) == 0);
    end

    check("push_count", obs_push_cnt, exp_push_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
